// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop counter: operating-mode encodings
// and the 2-bit mode type used by the counter and its environment.
package tff_pkg;

    // Operating modes presented on the MODE input.
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    // Widest counter the design is meant to be built at.
    localparam int unsigned TFF_MAX_WIDTH = 32;

    // Convert a raw 2-bit MODE bus into the enumerated mode.
    function automatic mode_e to_mode(input logic [1:0] raw);
        return mode_e'(raw);
    endfunction

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// One-bit T flip-flop with synchronous active-high reset, parallel load and
// a toggle input. Q and QN are both registered so QN never lags Q.
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic load_d_i,
    input  logic t_i,
    output logic q_o,
    output logic qn_o
);

    logic q_q;
    logic q_d;
    logic qn_q;

    // Next-state selection: reset beats load, load beats toggle.
    always_comb begin
        q_d = q_q;
        if (rst_i) begin
            q_d = RST_BIT;
        end else if (load_i) begin
            q_d = load_d_i;
        end else if (t_i) begin
            q_d = ~q_q;
        end
    end

    // State register; the complement is registered from the same next value.
    always_ff @(posedge clk_i) begin
        q_q  <= q_d;
        qn_q <= ~q_d;
    end

    assign q_o  = q_q;
    assign qn_o = qn_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// Up/down/toggle counter built from WIDTH T-flip-flop cells. The counter
// derives a per-bit toggle enable from a carry (UP) or borrow (DOWN) chain,
// or passes the T mask straight through in TOGGLE mode. Saturation for
// WRAP=0 is applied by suppressing all toggles at the limit.
module tff_counter
    import tff_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter bit                WRAP    = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] T,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC
);

    mode_e            mode;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [WIDTH:0]   carry_up;
    logic [WIDTH:0]   borrow_dn;
    logic             all_ones;
    logic             all_zero;
    logic             at_limit;
    logic [WIDTH-1:0] toggle_d;

    assign mode = to_mode(MODE);

    // Ripple chains: bit i toggles when every lower bit is 1 (UP) or 0 (DOWN).
    // The final stage of each chain doubles as the all-ones / all-zero detect.
    always_comb begin
        carry_up     = '0;
        borrow_dn    = '0;
        carry_up[0]  = 1'b1;
        borrow_dn[0] = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            carry_up[i+1]  = carry_up[i]  &  q_w[i];
            borrow_dn[i+1] = borrow_dn[i] & ~q_w[i];
        end
    end

    assign all_ones = carry_up[WIDTH];
    assign all_zero = borrow_dn[WIDTH];

    // Counter sits at the limit for the selected direction.
    assign at_limit = ((mode == MODE_UP)   && all_ones) ||
                      ((mode == MODE_DOWN) && all_zero);

    // Per-bit toggle enables; held at zero when disabled or saturated.
    always_comb begin
        toggle_d = '0;
        if (EN) begin
            unique case (mode)
                MODE_UP:     toggle_d = carry_up[WIDTH-1:0];
                MODE_DOWN:   toggle_d = borrow_dn[WIDTH-1:0];
                MODE_TOGGLE: toggle_d = T;
                default:     toggle_d = '0;
            endcase
            if (!WRAP && at_limit) begin
                toggle_d = '0;
            end
        end
    end

    // One T flip-flop per bit; reset value comes from the matching RST_VAL bit.
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        tff_cell #(
            .RST_BIT (RST_VAL[g])
        ) u_cell (
            .clk_i    (CLK),
            .rst_i    (RST),
            .load_i   (LOAD),
            .load_d_i (D[g]),
            .t_i      (toggle_d[g]),
            .q_o      (q_w[g]),
            .qn_o     (qn_w[g])
        );
    end

    assign Q  = q_w;
    assign QN = qn_w;

    // Terminal count looks at registered Q and the live MODE/EN, so it is
    // visible the cycle before a wrap and stays up while saturated.
    assign TC = EN && at_limit;

endmodule : tff_counter

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run against an
// arithmetic reference model, across four parameterisations.
module tb_tff_counter;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_TOG  = 2'b11;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] d8;
    logic [7:0] t8;

    logic [0:0] q1,  qn1;   logic tc1;
    logic [3:0] q4w, qn4w;  logic tc4w;
    logic [3:0] q4s, qn4s;  logic tc4s;
    logic [7:0] q8,  qn8;   logic tc8;

    int tests;
    int fails;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    tff_counter #(.WIDTH(1), .RST_VAL(1'b1),  .WRAP(1'b1)) u1 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t8[0:0]), .LOAD(load),
        .D(d8[0:0]), .Q(q1), .QN(qn1), .TC(tc1));
    tff_counter #(.WIDTH(4), .RST_VAL(4'h5),  .WRAP(1'b1)) u4w (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t8[3:0]), .LOAD(load),
        .D(d8[3:0]), .Q(q4w), .QN(qn4w), .TC(tc4w));
    tff_counter #(.WIDTH(4), .RST_VAL(4'h5),  .WRAP(1'b0)) u4s (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t8[3:0]), .LOAD(load),
        .D(d8[3:0]), .Q(q4s), .QN(qn4s), .TC(tc4s));
    tff_counter #(.WIDTH(8), .RST_VAL(8'hA5), .WRAP(1'b0)) u8 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .T(t8), .LOAD(load),
        .D(d8), .Q(q8), .QN(qn8), .TC(tc8));

    // ---------------- reference model ----------------
    function automatic int unsigned model_next(int w, bit wrap, int unsigned rv,
                                               int unsigned q, bit r, bit e,
                                               logic [1:0] m, bit l,
                                               int unsigned dd, int unsigned tt);
        int unsigned mx;
        mx = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        if (r) return rv;
        if (l) return dd & mx;
        if (!e) return q;
        case (m)
            M_UP:   return (q == mx) ? (wrap ? 0 : mx) : q + 1;
            M_DOWN: return (q == 0)  ? (wrap ? mx : 0) : q - 1;
            M_TOG:  return (q ^ tt) & mx;
            default: return q;
        endcase
    endfunction

    function automatic bit model_tc(int w, int unsigned q, bit e, logic [1:0] m);
        int unsigned mx;
        mx = (32'd1 << w) - 1;
        return e && (((m == M_UP) && (q == mx)) || ((m == M_DOWN) && (q == 0)));
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge so they settle well before the rising edge.
    task automatic drive(input bit r, input bit e, input logic [1:0] m,
                         input bit l, input logic [7:0] dd, input logic [7:0] tt);
        @(negedge clk);
        rst = r; en = e; mode = m; load = l; d8 = dd; t8 = tt;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table (checked on u4w) ----------------
    typedef struct {
        bit         rst;
        bit         en;
        logic [1:0] mode;
        bit         load;
        logic [3:0] d;
        logic [3:0] t;
        bit         exp_tc;   // before the edge
        logic [3:0] exp_q;    // after the edge
    } vec_t;

    function automatic vec_t mk(bit r, bit e, logic [1:0] m, bit l,
                                logic [3:0] dd, logic [3:0] tt,
                                bit etc, logic [3:0] eq);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.load = l; v.d = dd; v.t = tt;
        v.exp_tc = etc; v.exp_q = eq;
        return v;
    endfunction

    vec_t vecs[17];

    // Model state for the random phase
    int unsigned m1, m4w, m4s, m8;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; en = 1'b0; mode = M_HOLD; load = 1'b0; d8 = '0; t8 = '0;

        vecs[0]  = mk(1, 0, M_HOLD, 0, 4'h0, 4'h0, 0, 4'h5); // reset
        vecs[1]  = mk(0, 1, M_UP,   0, 4'h0, 4'h0, 0, 4'h6);
        vecs[2]  = mk(0, 1, M_UP,   0, 4'h0, 4'h0, 0, 4'h7);
        vecs[3]  = mk(0, 1, M_UP,   0, 4'h0, 4'h0, 0, 4'h8);
        vecs[4]  = mk(0, 0, M_HOLD, 1, 4'hE, 4'h0, 0, 4'hE); // load
        vecs[5]  = mk(0, 1, M_UP,   0, 4'h0, 4'h0, 0, 4'hF);
        vecs[6]  = mk(0, 1, M_UP,   0, 4'h0, 4'h0, 1, 4'h0); // wrap up
        vecs[7]  = mk(0, 1, M_DOWN, 0, 4'h0, 4'h0, 1, 4'hF); // wrap down
        vecs[8]  = mk(0, 1, M_TOG,  1, 4'hA, 4'h0, 0, 4'hA);
        vecs[9]  = mk(0, 1, M_TOG,  0, 4'h0, 4'h6, 0, 4'hC);
        vecs[10] = mk(0, 1, M_TOG,  0, 4'h0, 4'h0, 0, 4'hC);
        vecs[11] = mk(1, 1, M_UP,   1, 4'h3, 4'h0, 0, 4'h5); // reset beats load
        vecs[12] = mk(0, 1, M_UP,   1, 4'h3, 4'h0, 0, 4'h3);
        vecs[13] = mk(0, 0, M_UP,   0, 4'h0, 4'h0, 0, 4'h3);
        vecs[14] = mk(0, 1, M_UP,   1, 4'hF, 4'h0, 0, 4'hF);
        vecs[15] = mk(0, 1, M_UP,   1, 4'h1, 4'h0, 1, 4'h1); // load beats TC
        vecs[16] = mk(0, 1, M_HOLD, 0, 4'h0, 4'h0, 0, 4'h1);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].load,
                  {4'h0, vecs[i].d}, {4'h0, vecs[i].t});
            check($sformatf("vec%0d_tc", i), {31'd0, tc4w}, {31'd0, vecs[i].exp_tc});
            edge_settle();
            check($sformatf("vec%0d_q", i),  {28'd0, q4w},  {28'd0, vecs[i].exp_q});
            check($sformatf("vec%0d_qn", i), {28'd0, qn4w}, {28'd0, ~vecs[i].exp_q});
        end

        // ---------------- saturation sequence on u4s ----------------
        drive(0, 0, M_HOLD, 1, 8'h0F, 8'h00);
        edge_settle();
        check("sat_load_f", {28'd0, q4s}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, M_UP, 0, 8'h00, 8'h00);
            check($sformatf("sat_up_tc%0d", i), {31'd0, tc4s}, 32'd1);
            edge_settle();
            check($sformatf("sat_up_q%0d", i), {28'd0, q4s}, 32'hF);
        end
        drive(0, 0, M_HOLD, 1, 8'h00, 8'h00);
        edge_settle();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, M_DOWN, 0, 8'h00, 8'h00);
            check($sformatf("sat_dn_tc%0d", i), {31'd0, tc4s}, 32'd1);
            edge_settle();
            check($sformatf("sat_dn_q%0d", i), {28'd0, q4s}, 32'h0);
            check($sformatf("sat_dn_qn%0d", i), {28'd0, qn4s}, 32'hF);
        end

        // ---------------- reset mid-count on u4w ----------------
        drive(0, 1, M_UP, 1, 8'h09, 8'h00);
        edge_settle();
        drive(0, 1, M_UP, 0, 8'h00, 8'h00);
        edge_settle();
        check("mid_pre", {28'd0, q4w}, 32'hA);
        drive(1, 1, M_UP, 0, 8'h00, 8'h00);
        edge_settle();
        check("mid_rst", {28'd0, q4w}, 32'h5);
        drive(0, 1, M_UP, 0, 8'h00, 8'h00);
        edge_settle();
        check("mid_resume", {28'd0, q4w}, 32'h6);

        // ---------------- randomized run against the model ----------------
        drive(1, 0, M_HOLD, 0, 8'h00, 8'h00);
        edge_settle();
        m1 = 1; m4w = 5; m4s = 5; m8 = 8'hA5;
        for (int c = 0; c < 1000; c++) begin
            bit         r, e, l;
            logic [1:0] m;
            logic [7:0] dd, tt;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 4) != 0);
            m  = 2'($urandom_range(0, 3));
            dd = 8'($urandom);
            tt = 8'($urandom);
            // Bias toward limits so wrap/saturation paths get exercised.
            if ($urandom_range(0, 15) == 0) begin
                l  = 1'b1;
                dd = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            end
            drive(r, e, m, l, dd, tt);
            check("rnd_tc1",  {31'd0, tc1},  {31'd0, model_tc(1, m1, e, m)});
            check("rnd_tc4w", {31'd0, tc4w}, {31'd0, model_tc(4, m4w, e, m)});
            check("rnd_tc4s", {31'd0, tc4s}, {31'd0, model_tc(4, m4s, e, m)});
            check("rnd_tc8",  {31'd0, tc8},  {31'd0, model_tc(8, m8, e, m)});
            m1  = model_next(1, 1'b1, 1,     m1,  r, e, m, l, dd, tt);
            m4w = model_next(4, 1'b1, 5,     m4w, r, e, m, l, dd, tt);
            m4s = model_next(4, 1'b0, 5,     m4s, r, e, m, l, dd, tt);
            m8  = model_next(8, 1'b0, 8'hA5, m8,  r, e, m, l, dd, tt);
            edge_settle();
            check("rnd_q1",   {31'd0, q1},   m1);
            check("rnd_qn1",  {31'd0, qn1},  {31'd0, ~m1[0]});
            check("rnd_q4w",  {28'd0, q4w},  m4w);
            check("rnd_qn4w", {28'd0, qn4w}, {28'd0, ~m4w[3:0]});
            check("rnd_q4s",  {28'd0, q4s},  m4s);
            check("rnd_qn4s", {28'd0, qn4s}, {28'd0, ~m4s[3:0]});
            check("rnd_q8",   {24'd0, q8},   m8);
            check("rnd_qn8",  {24'd0, qn8},  {24'd0, ~m8[7:0]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_tff_counter

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter/register width in bits, legal range 1..32.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into Q on reset.
REQ-003 Parameter WRAP, default 1: 1 = modular wrap at the count limits, 0 = saturate at the limits.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 EN  input  1  count/toggle enable; when low, Q holds (LOAD still acts).
REQ-007 MODE  input  2  operation: 00 HOLD, 01 UP, 10 DOWN, 11 TOGGLE.
REQ-008 T  input  WIDTH  per-bit toggle mask, used only in TOGGLE mode.
REQ-009 LOAD  input  1  parallel-load strobe.
REQ-010 D  input  WIDTH  parallel-load data.
REQ-011 Q  output  WIDTH  registered state.
REQ-012 QN  output  WIDTH  registered complement of Q.
REQ-013 TC  output  1  terminal-count flag, combinational from registered Q and the current MODE/EN.

Function
REQ-014 Per-edge priority: RST > LOAD > (EN and MODE) > hold.
REQ-015 LOAD=1 (RST=0): Q <= D next edge, regardless of EN, MODE or T.
REQ-016 EN=0 or MODE=HOLD (no LOAD): Q unchanged.
REQ-017 UP (EN=1): Q <= Q+1 mod 2^WIDTH; with WRAP=0, Q stays at all-ones when already all-ones.
REQ-018 DOWN (EN=1): Q <= Q-1 mod 2^WIDTH; with WRAP=0, Q stays at 0 when already 0.
REQ-019 TOGGLE (EN=1): each bit i <= Q[i] XOR T[i]; T=0 holds; WRAP has no effect.
REQ-020 UP/DOWN are built from T-flip-flop cells: bit i toggles when all lower bits are 1 (UP) or all 0 (DOWN); bit 0 always toggles.
REQ-021 QN equals ~Q on every cycle, including the reset cycle and load cycles; no one-cycle lag.
REQ-022 TC = EN & ((MODE=UP & Q=all-ones) | (MODE=DOWN & Q=0)); TC=0 in HOLD and TOGGLE modes.
REQ-023 TC asserts in both WRAP settings; in WRAP=0 it stays high while the counter is held saturated.
REQ-024 A MODE change takes effect on the next edge; there is no pipeline and no latency beyond one clock.
REQ-025 Simultaneous LOAD and a TC condition: the load wins; TC still reflects pre-edge Q that cycle.

Reset
REQ-026 RST=1 at an edge: Q <= RST_VAL and QN <= ~RST_VAL, overriding LOAD, EN and MODE.
REQ-027 Reset asserted mid-count takes effect at the next edge; counting resumes from RST_VAL the first edge after RST falls.
REQ-028 Before the first reset edge, Q is unspecified; no output is guaranteed until reset.

Structure
REQ-029 Shared package tff_pkg holds the MODE encodings (MODE_HOLD, MODE_UP, MODE_DOWN, MODE_TOGGLE) and the 2-bit mode typedef.
REQ-030 One sub-module, tff_cell: 1-bit T flip-flop with synchronous active-high reset value, load, load data and toggle input, driving Q/QN; tff_counter instantiates WIDTH of these via generate.
REQ-031 The carry/borrow toggle-enable chain and the saturation gating live in tff_counter, not in tff_cell.

Verification (WIDTH=4 unless stated)
REQ-032 Scenario: RST=1 for 1 edge, RST_VAL=4'h5 -> Q=5, QN=4'hA; then MODE=UP, EN=1 for 3 edges -> Q=8, QN=7.
REQ-033 Scenario: WRAP=1, LOAD D=4'hE, then UP 2 edges -> Q=F with TC=1, then Q=0 with TC=0; DOWN from 0 -> TC=1, Q=F next edge.
REQ-034 Scenario: WRAP=0, Q=F, UP 3 edges -> Q stays F and TC stays 1; Q=0, DOWN -> Q stays 0 and TC=1.
REQ-035 Scenario: MODE=TOGGLE, Q=4'b1010, T=4'b0110 -> Q=4'b1100; T=0 -> Q unchanged; TC=0 throughout.
REQ-036 Scenario: LOAD=1, D=3, MODE=UP, RST=1 on the same edge -> Q=RST_VAL; next edge with RST=0 and LOAD=1 -> Q=3; EN=0, LOAD=0 -> Q holds 3.
REQ-037 Scenario: random stimulus of 1000 cycles at WIDTH=1, 4 and 8 -> QN==~Q every cycle, and Q matches a behavioural reference model.
